led_frame_sched: RTL and testbench
==================================

# led_frame_sched

GCK-domain frame scheduler for the LED display controller's double-buffered greyscale SRAM. It owns the ping-pong bank select between the SRAM being filled from DCK and the SRAM being displayed. On every Vsync it swaps banks when a complete frame is available, then sequences line-by-line burst reads of the display bank into the PWM generator's channel registers. It sits between the SRAM read ports (AA/CENA/QA) and pwm_gen, replacing ad-hoc read sequencing inside the PWM engine.

## Interface

Parameters:
- LINES, 32, scan lines per frame
- CH, 16, channels (words) per line; LINES*CH ≤ 512
- AW, 9, SRAM address width

Ports:
- GCK  in  1  greyscale clock; sole clock of the block
- rst  in  1  asynchronous, active-low reset
- Vsync  in  1  frame sync, synchronous to GCK
- wr_frame_done  in  1  one-cycle pulse, GCK domain: the write bank now holds a complete frame
- pwm_line_done  in  1  one-cycle pulse: PWM engine has finished displaying the current line
- rd_bank  out  1  bank being displayed; write bank is ~rd_bank
- AA  out  AW  read address to the rd_bank SRAM
- CENA  out  1  read enable, active-low
- ld_valid  out  1  QA of rd_bank SRAM is valid this cycle
- ld_idx  out  4  channel index of the word on QA
- line_start  out  1  one-cycle pulse: all CH words of a line are loaded, PWM may start
- line_idx  out  5  current line number
- frame_done  out  1  one-cycle pulse: last line finished
- frame_missed  out  1  one-cycle pulse: Vsync arrived with no new frame pending, so the bank was repeated
- frame_overrun  out  1  one-cycle pulse: Vsync arrived while a frame was still being sequenced

## Operation

- The FSM has four states: IDLE, FETCH, DRAIN, WAIT_PWM.
- pending flag: set by wr_frame_done, cleared at a swap.
- Vsync rise is detected when Vsync = 1 and the previous sample is 0. On a rise, in any state:
  - if pending (or wr_frame_done in the same cycle): toggle rd_bank and clear pending;
  - else: keep rd_bank and pulse frame_missed;
  - if the state was not IDLE: pulse frame_overrun;
  - then set line = 0, ch = 0, and enter FETCH.
- FETCH: drive CENA = 0 and AA = line*CH + ch, i.e. {line, ch[3:0]}. ch increments each cycle. After ch = CH−1, go to DRAIN.
- DRAIN: one cycle that covers the SRAM read latency. Then pulse line_start and enter WAIT_PWM.
- ld_valid/ld_idx are the CENA-low/ch values delayed by one cycle.
- WAIT_PWM, on pwm_line_done:
  - if line = LINES−1: pulse frame_done and go to IDLE;
  - else: line++, ch = 0, go to FETCH.
- pwm_line_done outside WAIT_PWM is ignored.
- A wr_frame_done arriving with pending already set keeps pending = 1. There is no count; the newest frame overwrites in the write bank.
- Vsync rise takes priority over pwm_line_done in the same cycle.

## Timing

- Reset values: state IDLE, rd_bank 0, pending 0, CENA 1, AA 0, ld_valid 0, ld_idx 0, line_idx 0, all strobes 0.
- E0 is the GCK edge that samples the Vsync rise.
  - rd_bank updates at E0.
  - CENA is low for the 16 cycles following E0..E15, with AA = base+0..base+15.
  - ld_valid is high for the 16 cycles following E1..E16.
  - line_start is high in the cycle following E17.
- pwm_line_done sampled at edge Ek (line < LINES−1): next burst CENA low in the cycles following Ek..Ek+15. Fetch-to-line_start latency is always CH+2 cycles.
- All outputs are registered.
- Reset asserted mid-burst: CENA returns to 1 immediately (async), with no partial line_start.

## Structure

- Package led_sched_pkg holds:
  - LINES, CH, AW constants;
  - the state enum (IDLE, FETCH, DRAIN, WAIT_PWM);
  - the line/channel index widths.
- One sub-module, vsync_edge: Vsync sample register and rise pulse. It is shared with pwm_gen's existing Vsync_pulse logic.
- Bank toggle, pending flag and FSM stay in the top.

## Test plan

- Reset, then wr_frame_done, then Vsync rise → rd_bank 0→1; AA 0..15 with CENA=0 over 16 cycles; ld_idx 0..15; line_start at cycle 18.
- Vsync rise with no wr_frame_done → rd_bank unchanged, frame_missed = 1 for one cycle, line 0 still fetched.
- Full frame: 32 pwm_line_done pulses → bursts at AA bases 0, 16, …, 496; frame_done after the 32nd; FSM back in IDLE.
- Vsync rise during line 7 WAIT_PWM → frame_overrun = 1, line_idx = 0, new burst at AA = 0.
- wr_frame_done and Vsync rise in the same cycle → swap occurs, pending = 0 afterwards, no frame_missed.
- rst low during FETCH at ch = 5 → CENA = 1, ld_valid = 0, rd_bank = 0 within the same cycle. After release, nothing happens until the next Vsync.

Source files
------------

// File: rtl/led_frame_sched_pkg.sv
// -----------------------------------------------------------------------------
// led_sched_pkg
// Shared constants and types for the GCK-domain frame scheduler.
//   LINES  : scan lines per frame
//   CH     : greyscale words (channels) per line
//   AW     : SRAM read address width; {line, ch} must fill it exactly
//   state_e: scheduler FSM states
// -----------------------------------------------------------------------------
package led_sched_pkg;

  localparam int LINES  = 32;
  localparam int CH     = 16;
  localparam int AW     = 9;
  localparam int LINE_W = $clog2(LINES);
  localparam int CH_W   = $clog2(CH);

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [CH_W-1:0]   ch_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_PWM
  } state_e;

  // Lines are CH words apart, and CH is a power of two, so the read
  // address is a plain concatenation rather than a multiply-add.
  function automatic logic [AW-1:0] rd_addr(input line_t line, input ch_t ch);
    return AW'({line, ch});
  endfunction

endpackage

// File: rtl/led_frame_sched_if.sv
// -----------------------------------------------------------------------------
// led_frame_sched_if
// Groups the scheduler's frame/line handshakes and SRAM read-port signals.
//   Vsync, wr_frame_done, pwm_line_done : into the scheduler
//   rd_bank, AA, CENA                   : SRAM bank select and read port
//   ld_valid, ld_idx, line_start        : channel-register load to pwm_gen
//   line_idx, frame_done                : line progress
//   frame_missed, frame_overrun         : frame-level status strobes
// Modports: slave = scheduler side, master = surrounding system.
// -----------------------------------------------------------------------------
interface led_frame_sched_if;
  import led_sched_pkg::*;

  logic              Vsync;
  logic              wr_frame_done;
  logic              pwm_line_done;
  logic              rd_bank;
  logic [AW-1:0]     AA;
  logic              CENA;
  logic              ld_valid;
  logic [CH_W-1:0]   ld_idx;
  logic              line_start;
  logic [LINE_W-1:0] line_idx;
  logic              frame_done;
  logic              frame_missed;
  logic              frame_overrun;

  modport slave (
    input  Vsync, wr_frame_done, pwm_line_done,
    output rd_bank, AA, CENA, ld_valid, ld_idx, line_start, line_idx,
           frame_done, frame_missed, frame_overrun
  );

  modport master (
    output Vsync, wr_frame_done, pwm_line_done,
    input  rd_bank, AA, CENA, ld_valid, ld_idx, line_start, line_idx,
           frame_done, frame_missed, frame_overrun
  );

endinterface

// File: rtl/led_frame_sched_vsync_edge.sv
// -----------------------------------------------------------------------------
// vsync_edge
// Samples Vsync once per GCK and flags the cycle in which it rises.
//   GCK     : clock
//   rst     : asynchronous active-low reset
//   vsync_i : frame sync, already synchronous to GCK
//   rise_o  : high while vsync_i = 1 and the previous sample was 0
// -----------------------------------------------------------------------------
module vsync_edge (
  input  logic GCK,
  input  logic rst,
  input  logic vsync_i,
  output logic rise_o
);

  logic vsync_q;

  always_ff @(posedge GCK or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  assign rise_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/led_frame_sched.sv
// -----------------------------------------------------------------------------
// led_frame_sched
// Ping-pong bank owner and line-burst sequencer between the greyscale SRAM
// read port and pwm_gen. A Vsync rise swaps banks if a full frame is waiting
// and restarts the frame; each line is fetched as a CH-word burst, followed
// by one drain cycle for SRAM read latency, then line_start.
//   GCK : clock
//   rst : asynchronous active-low reset
//   bus : led_frame_sched_if.slave (see interface header for signal list)
// All interface outputs come straight from registers.
// -----------------------------------------------------------------------------
module led_frame_sched
  import led_sched_pkg::*;
(
  input logic              GCK,
  input logic              rst,
  led_frame_sched_if.slave bus
);

  state_e        state_q, state_d;
  line_t         line_q, line_d;
  ch_t           ch_q, ch_d;
  logic          rd_bank_q, rd_bank_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] aa_q, aa_d;
  logic          cena_q, cena_d;
  logic          ld_valid_q;
  ch_t           ld_idx_q;
  logic          line_start_q, line_start_d;
  logic          frame_done_q, frame_done_d;
  logic          missed_q, missed_d;
  logic          overrun_q, overrun_d;
  logic          vsync_rise;

  vsync_edge u_vsync_edge (
    .GCK     (GCK),
    .rst     (rst),
    .vsync_i (bus.Vsync),
    .rise_o  (vsync_rise)
  );

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    ch_d         = ch_q;
    rd_bank_d    = rd_bank_q;
    // Repeated wr_frame_done just re-asserts pending: the writer has
    // overwritten the same write bank with a newer frame.
    pending_d    = pending_q | bus.wr_frame_done;
    line_start_d = 1'b0;
    frame_done_d = 1'b0;
    missed_d     = 1'b0;
    overrun_d    = 1'b0;

    // A frame sync restarts sequencing from any state and beats a
    // simultaneous pwm_line_done.
    if (vsync_rise) begin
      if (pending_q || bus.wr_frame_done) begin
        rd_bank_d = ~rd_bank_q;
        pending_d = 1'b0;
      end else begin
        missed_d  = 1'b1;
      end
      overrun_d = (state_q != IDLE);
      line_d    = '0;
      ch_d      = '0;
      state_d   = FETCH;
    end else begin
      case (state_q)
        IDLE: ;
        FETCH: begin
          if (ch_q == ch_t'(CH - 1)) begin
            state_d = DRAIN;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
        DRAIN: begin
          line_start_d = 1'b1;
          state_d      = WAIT_PWM;
        end
        WAIT_PWM: begin
          if (bus.pwm_line_done) begin
            if (line_q == line_t'(LINES - 1)) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              line_d  = line_q + 1'b1;
              ch_d    = '0;
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Read port is registered from next-state so the first word of a burst
    // is presented in the cycle right after the triggering edge.
    cena_d = (state_d != FETCH);
    aa_d   = cena_d ? aa_q : rd_addr(line_d, ch_d);
  end

  always_ff @(posedge GCK or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      line_q       <= '0;
      ch_q         <= '0;
      rd_bank_q    <= 1'b0;
      pending_q    <= 1'b0;
      aa_q         <= '0;
      cena_q       <= 1'b1;
      ld_valid_q   <= 1'b0;
      ld_idx_q     <= '0;
      line_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      missed_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      ch_q         <= ch_d;
      rd_bank_q    <= rd_bank_d;
      pending_q    <= pending_d;
      aa_q         <= aa_d;
      cena_q       <= cena_d;
      // QA is valid one cycle after a CENA-low cycle; the low address bits
      // are the channel index of that word.
      ld_valid_q   <= ~cena_q;
      ld_idx_q     <= aa_q[CH_W-1:0];
      line_start_q <= line_start_d;
      frame_done_q <= frame_done_d;
      missed_q     <= missed_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.rd_bank       = rd_bank_q;
  assign bus.AA            = aa_q;
  assign bus.CENA          = cena_q;
  assign bus.ld_valid      = ld_valid_q;
  assign bus.ld_idx        = ld_idx_q;
  assign bus.line_start    = line_start_q;
  assign bus.line_idx      = line_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_missed  = missed_q;
  assign bus.frame_overrun = overrun_q;

endmodule

// File: tb/tb_led_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_led_frame_sched
// Table of frame-start scenarios (pre-Vsync wr_frame_done pulses, same-cycle
// wr_frame_done, number of lines run, expected swap/missed/overrun), plus
// hand-written sequences for idle line_done, reset mid-burst and restart.
// Burst reads, loads and line_start timing are checked through a scoreboard.
// -----------------------------------------------------------------------------
module tb_led_frame_sched;
  import led_sched_pkg::*;

  logic GCK = 1'b0;
  logic rst;

  always #5 GCK = ~GCK;

  led_frame_sched_if bus ();

  led_frame_sched u_dut (
    .GCK (GCK),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   exp_aa[$];
  int   exp_ld[$];
  int   exp_ls[$];
  int   exp_fm_cyc = -1;
  int   exp_fo_cyc = -1;
  int   exp_fd_cyc = -1;
  logic exp_bank   = 1'b0;
  int   cur_line   = 0;

  typedef struct {
    int n_pre;
    bit same_wfd;
    int n_done;
    bit exp_swap;
    bit exp_missed;
    bit exp_overrun;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock; observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge GCK);
    #1;
    cyc++;
    if (bus.CENA === 1'b0) begin
      if (exp_aa.size() == 0) chk("unexpected_read", 32'(bus.CENA), 32'd1);
      else                    chk("AA", 32'(bus.AA), 32'(exp_aa.pop_front()));
    end else if (bus.CENA !== 1'b1) begin
      chk("CENA_known", 32'(bus.CENA), 32'd1);
    end
    if (bus.ld_valid !== 1'b0) begin
      if (exp_ld.size() == 0) chk("unexpected_ld_valid", 32'(bus.ld_valid), 32'd0);
      else                    chk("ld_idx", 32'(bus.ld_idx), 32'(exp_ld.pop_front()));
    end
    if (bus.line_start === 1'b1) begin
      if (exp_ls.size() == 0) chk("unexpected_line_start", 32'(bus.line_start), 32'd0);
      else                    chk("line_start_cycle", 32'(cyc), 32'(exp_ls.pop_front()));
    end else if (exp_ls.size() > 0 && cyc >= exp_ls[0]) begin
      chk("line_start_missing", 32'(bus.line_start), 32'd1);
      void'(exp_ls.pop_front());
    end
    chk("frame_missed",  32'(bus.frame_missed),  32'(cyc == exp_fm_cyc));
    chk("frame_overrun", 32'(bus.frame_overrun), 32'(cyc == exp_fo_cyc));
    chk("frame_done",    32'(bus.frame_done),    32'(cyc == exp_fd_cyc));
    chk("rd_bank",       32'(bus.rd_bank),       32'(exp_bank));
  endtask

  // Called in the cycle the trigger is driven; the burst starts next edge.
  task automatic push_burst(input int line);
    for (int i = 0; i < CH; i++) begin
      exp_aa.push_back(line * CH + i);
      exp_ld.push_back(i);
    end
    exp_ls.push_back(cyc + CH + 2);
  endtask

  task automatic wait_ls();
    int guard;
    guard = 0;
    while (exp_ls.size() > 0 && guard < 60) begin
      tick();
      guard++;
    end
    chk("line_start_timeout", 32'(exp_ls.size()), 32'd0);
    chk("reads_leftover",     32'(exp_aa.size()), 32'd0);
    chk("loads_leftover",     32'(exp_ld.size()), 32'd0);
  endtask

  task automatic pulse_wfd();
    bus.wr_frame_done = 1'b1;
    tick();
    bus.wr_frame_done = 1'b0;
    tick();
  endtask

  task automatic vsync(input bit same_wfd, input bit exp_swap, input bit exp_missed,
                       input bit exp_overrun);
    bus.Vsync         = 1'b1;
    bus.wr_frame_done = same_wfd;
    push_burst(0);
    cur_line = 0;
    if (exp_swap) exp_bank = ~exp_bank;
    exp_fm_cyc = exp_missed  ? cyc + 1 : -1;
    exp_fo_cyc = exp_overrun ? cyc + 1 : -1;
    tick();
    bus.wr_frame_done = 1'b0;
    chk("line_idx_after_vsync", 32'(bus.line_idx), 32'd0);
    // Vsync held high a second cycle: only the rise may count.
    tick();
    bus.Vsync = 1'b0;
    wait_ls();
  endtask

  task automatic line_done();
    bus.pwm_line_done = 1'b1;
    if (cur_line == LINES - 1) begin
      exp_fd_cyc = cyc + 1;
    end else begin
      cur_line++;
      push_burst(cur_line);
    end
    tick();
    bus.pwm_line_done = 1'b0;
    chk("line_idx", 32'(bus.line_idx), 32'(cur_line));
    if (exp_ls.size() > 0) wait_ls();
    else                   tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          n_pre same n_done swap missed overrun
    vecs[0] = '{1,    1'b0, 1,  1'b1, 1'b0, 1'b0};  // normal swap from idle
    vecs[1] = '{0,    1'b0, 32, 1'b0, 1'b1, 1'b1};  // repeat bank, full frame
    vecs[2] = '{0,    1'b1, 7,  1'b1, 1'b0, 1'b0};  // same-cycle wr_frame_done
    vecs[3] = '{1,    1'b0, 0,  1'b1, 1'b0, 1'b1};  // Vsync during line 7 wait
    vecs[4] = '{2,    1'b0, 32, 1'b1, 1'b0, 1'b1};  // double frame_done, one swap
    vecs[5] = '{0,    1'b0, 2,  1'b0, 1'b1, 1'b0};  // pending cleared by swap
    vecs[6] = '{1,    1'b1, 0,  1'b1, 1'b0, 1'b1};  // pending plus same-cycle
    vecs[7] = '{0,    1'b0, 32, 1'b0, 1'b1, 1'b1};  // nothing left pending

    bus.Vsync         = 1'b0;
    bus.wr_frame_done = 1'b0;
    bus.pwm_line_done = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_CENA",          32'(bus.CENA),          32'd1);
    chk("rst_AA",            32'(bus.AA),            32'd0);
    chk("rst_ld_valid",      32'(bus.ld_valid),      32'd0);
    chk("rst_ld_idx",        32'(bus.ld_idx),        32'd0);
    chk("rst_line_idx",      32'(bus.line_idx),      32'd0);
    chk("rst_rd_bank",       32'(bus.rd_bank),       32'd0);
    chk("rst_line_start",    32'(bus.line_start),    32'd0);
    chk("rst_frame_done",    32'(bus.frame_done),    32'd0);
    chk("rst_frame_missed",  32'(bus.frame_missed),  32'd0);
    chk("rst_frame_overrun", 32'(bus.frame_overrun), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 8; v++) begin
      repeat (vecs[v].n_pre) pulse_wfd();
      vsync(vecs[v].same_wfd, vecs[v].exp_swap, vecs[v].exp_missed, vecs[v].exp_overrun);
      repeat (vecs[v].n_done) line_done();
      repeat (3) tick();
    end

    // pwm_line_done while idle must not start anything.
    bus.pwm_line_done = 1'b1;
    tick();
    bus.pwm_line_done = 1'b0;
    repeat (20) tick();
    chk("idle_line_idx", 32'(bus.line_idx), 32'(LINES - 1));

    // Reset asserted in the middle of a burst.
    pulse_wfd();
    bus.Vsync = 1'b1;
    push_burst(0);
    exp_bank   = ~exp_bank;
    exp_fm_cyc = -1;
    exp_fo_cyc = -1;
    tick();
    bus.Vsync = 1'b0;
    repeat (5) tick();
    chk("AA_at_ch5",   32'(bus.AA),   32'd5);
    chk("CENA_at_ch5", 32'(bus.CENA), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_CENA",       32'(bus.CENA),       32'd1);
    chk("midrst_ld_valid",   32'(bus.ld_valid),   32'd0);
    chk("midrst_rd_bank",    32'(bus.rd_bank),    32'd0);
    chk("midrst_line_start", 32'(bus.line_start), 32'd0);
    exp_aa.delete();
    exp_ld.delete();
    exp_ls.delete();
    exp_bank = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (30) tick();

    // Reset cleared pending: the next Vsync repeats bank 0.
    vsync(1'b0, 1'b0, 1'b1, 1'b0);
    line_done();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
